comp_bist: RTL and testbench



---
 rtl/comp_bist_pkg.sv | 27 ++
 rtl/comp_bist_if.sv | 31 +++
 rtl/comp_bist_ref.sv | 20 ++
 rtl/comp_bist.sv | 119 +++++++++++
 tb/tb_comp_bist.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/comp_bist_pkg.sv
// comp_bist_pkg: shared types and sizing helpers for the comparator self-test.
package comp_bist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Bit positions inside the 3-bit flag vector {o1, o2, o3}.
    localparam int GT = 2;
    localparam int EQ = 1;
    localparam int LT = 0;

    // Number of {a,b} vectors in one exhaustive run.
    function automatic int vec_count(input int w);
        return 1 << (2 * w);
    endfunction

    // fail_count is one bit wider than the vector index so a run in which
    // every vector fails still fits.
    function automatic int fail_width(input int w);
        return 2 * w + 1;
    endfunction

endpackage

// File: rtl/comp_bist_if.sv
// comp_bist_if: bundle between the self-test engine (master) and the
// comparator / supervising logic (slave).
interface comp_bist_if
    import comp_bist_pkg::*;
#(
    parameter int W = 1
);
    logic                       start;
    logic [W-1:0]               a_out;
    logic [W-1:0]               b_out;
    logic                       o1_in;
    logic                       o2_in;
    logic                       o3_in;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic [fail_width(W)-1:0]   fail_count;
    logic [W-1:0]               err_a;
    logic [W-1:0]               err_b;

    modport master (
        input  start, o1_in, o2_in, o3_in,
        output a_out, b_out, busy, done, pass, fail_count, err_a, err_b
    );

    modport slave (
        output start, o1_in, o2_in, o3_in,
        input  a_out, b_out, busy, done, pass, fail_count, err_a, err_b
    );

endinterface

// File: rtl/comp_bist_ref.sv
// comp_bist_ref: golden magnitude compare, flags ordered {a>b, a==b, a<b}.
module comp_bist_ref
    import comp_bist_pkg::*;
#(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [2:0]   flags
);

    // Unsigned compare; exactly one flag is ever set.
    always_comb begin
        flags     = '0;
        flags[GT] = (a > b);
        flags[EQ] = (a == b);
        flags[LT] = (a < b);
    end

endmodule

// File: rtl/comp_bist.sv
// comp_bist: walks every {a,b} operand pair into a magnitude comparator,
// holds each pair SETTLE cycles, then checks the returned flags.
//
// Optional build macro COMP_BIST_STOP_ON_FAIL_EN: when defined the run ends
// at the first mismatching vector and a_out/b_out stay on it for debug.
//
// state | meaning
// IDLE  | waiting for start, all results cleared
// WAIT  | holding the current vector while the comparator settles
// CHECK | sampling o1/o2/o3 against the reference, advancing the vector
// DONE  | results valid, last vector held, start restarts the run
module comp_bist
    import comp_bist_pkg::*;
#(
    parameter int W      = 1,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    comp_bist_if.master     bus
);

    localparam int VW = 2 * W;
    localparam int FW = fail_width(W);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [VW-1:0] LAST   = VW'(vec_count(W) - 1);
    localparam logic [CW-1:0] RELOAD = CW'(SETTLE - 1);

    state_t         state;
    logic [VW-1:0]  vec;
    logic [CW-1:0]  settle_cnt;
    logic [2:0]     exp_flags;
    logic [2:0]     obs_flags;
    logic           mismatch;
    logic           last_vec;
    logic [FW-1:0]  fail_nxt;

    comp_bist_ref #(.W(W)) u_ref (
        .a     (vec[VW-1:W]),
        .b     (vec[W-1:0]),
        .flags (exp_flags)
    );

    // Operands come straight from the vector register, so they are registered
    // and hold their value through DONE.
    assign bus.a_out = vec[VW-1:W];
    assign bus.b_out = vec[W-1:0];

    // Any deviation counts, including no-flag and multi-flag responses.
    assign obs_flags = {bus.o1_in, bus.o2_in, bus.o3_in};
    assign mismatch  = (obs_flags != exp_flags);
    assign last_vec  = (vec == LAST);
    assign fail_nxt  = bus.fail_count + FW'(1);

    // Sequencer, result capture and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            vec            <= '0;
            settle_cnt     <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.pass       <= 1'b0;
            bus.fail_count <= '0;
            bus.err_a      <= '0;
            bus.err_b      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state          <= WAIT;
                        vec            <= '0;
                        settle_cnt     <= RELOAD;
                        bus.busy       <= 1'b1;
                        bus.done       <= 1'b0;
                        bus.pass       <= 1'b0;
                        bus.fail_count <= '0;
                        bus.err_a      <= '0;
                        bus.err_b      <= '0;
                    end
                end
                WAIT: begin
                    if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CW'(1);
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        bus.fail_count <= fail_nxt;
                        if (bus.fail_count == '0) begin
                            bus.err_a <= vec[VW-1:W];
                            bus.err_b <= vec[W-1:0];
                        end
                    end
`ifdef COMP_BIST_STOP_ON_FAIL_EN
                    if (mismatch || last_vec) begin
`else
                    if (last_vec) begin
`endif
                        state    <= DONE;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                        bus.pass <= (bus.fail_count == '0) && !mismatch;
                    end else begin
                        state      <= WAIT;
                        vec        <= vec + VW'(1);
                        settle_cnt <= RELOAD;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_comp_bist.sv
// tb_comp_bist: drives two engines (W=1/SETTLE=1 and W=2/SETTLE=3) against a
// behavioural comparator with per-vector fault masks, and predicts the run
// outcome from the mask table alone.
module tb_comp_bist;

    logic clk = 1'b0;
    logic rst;
    logic st;
    logic sel;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    comp_bist_if #(.W(1)) if1 ();
    comp_bist_if #(.W(2)) if2 ();

    comp_bist #(.W(1), .SETTLE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    comp_bist #(.W(2), .SETTLE(3)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    // Fault mask per vector: bits set here are flipped in the comparator reply.
    logic [2:0] mask1 [4];
    logic [2:0] mask2 [16];

    function automatic logic [2:0] ref_flags(input int a, input int b);
        return {a > b, a == b, a < b};
    endfunction

    logic [2:0] f1, f2;
    assign f1 = ref_flags(int'(if1.a_out), int'(if1.b_out)) ^ mask1[{if1.a_out, if1.b_out}];
    assign f2 = ref_flags(int'(if2.a_out), int'(if2.b_out)) ^ mask2[{if2.a_out, if2.b_out}];
    assign if1.o1_in = f1[2];
    assign if1.o2_in = f1[1];
    assign if1.o3_in = f1[0];
    assign if2.o1_in = f2[2];
    assign if2.o2_in = f2[1];
    assign if2.o3_in = f2[0];
    assign if1.start = st & ~sel;
    assign if2.start = st & sel;

    int o_a, o_b, o_busy, o_done, o_pass, o_fc, o_ea, o_eb;
    always_comb begin
        if (sel) begin
            o_a = int'(if2.a_out);  o_b = int'(if2.b_out);
            o_busy = int'(if2.busy); o_done = int'(if2.done); o_pass = int'(if2.pass);
            o_fc = int'(if2.fail_count); o_ea = int'(if2.err_a); o_eb = int'(if2.err_b);
        end else begin
            o_a = int'(if1.a_out);  o_b = int'(if1.b_out);
            o_busy = int'(if1.busy); o_done = int'(if1.done); o_pass = int'(if1.pass);
            o_fc = int'(if1.fail_count); o_ea = int'(if1.err_a); o_eb = int'(if1.err_b);
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, o_a, 0);
        chk({tag, "_b"}, o_b, 0);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_done"}, o_done, 0);
        chk({tag, "_pass"}, o_pass, 0);
        chk({tag, "_fc"}, o_fc, 0);
        chk({tag, "_ea"}, o_ea, 0);
        chk({tag, "_eb"}, o_eb, 0);
    endtask

    // mode 0 good, 1 o2 stuck 0, 2 all flags stuck 1, 3 o1 stuck 0, else random
    task automatic setup(input bit s, input int mode);
        int w, n, a, b;
        logic [2:0] e, m;
        w = s ? 2 : 1;
        n = 1 << (2 * w);
        for (int i = 0; i < n; i++) begin
            a = i >> w;
            b = i & ((1 << w) - 1);
            e = ref_flags(a, b);
            case (mode)
                0: m = 3'b000;
                1: m = e & 3'b010;
                2: m = ~e;
                3: m = e & 3'b100;
                default: m = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            endcase
            if (s) mask2[i] = m;
            else   mask1[i] = m;
        end
    endtask

    task automatic run(input bit s, input int mid, input int rst_at);
        int w, settle, n, first, exp_fc, stopk, total, cyc, idx;
        logic [2:0] m;
        w = s ? 2 : 1;
        settle = s ? 3 : 1;
        n = 1 << (2 * w);
        first = -1;
        exp_fc = 0;
        for (int i = 0; i < n; i++) begin
            m = s ? mask2[i] : mask1[i];
            if (m != 3'b000) begin
                exp_fc++;
                if (first < 0) first = i;
            end
        end
        stopk = n - 1;
`ifdef COMP_BIST_STOP_ON_FAIL_EN
        if (first >= 0) begin
            exp_fc = 1;
            stopk = first;
        end
`endif
        total = (stopk + 1) * (settle + 1);

        @(negedge clk);
        sel = s;
        st = 1'b1;
        @(posedge clk);
        #1;
        st = 1'b0;
        cyc = 0;
        while (o_done == 0 && cyc < total + 20) begin
            idx = cyc / (settle + 1);
            if (idx > stopk) idx = stopk;
            chk("a_step", o_a, idx >> w);
            chk("b_step", o_b, idx & ((1 << w) - 1));
            chk("busy_run", o_busy, 1);
            if (cyc == rst_at) begin
                rst = 1'b1;
                #1;
                check_zero("async_rst");
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            st = (cyc + 1 == mid);
            @(posedge clk);
            #1;
            st = 1'b0;
            cyc++;
        end
        chk("done_cycle", cyc, total);
        chk("done", o_done, 1);
        chk("busy_done", o_busy, 0);
        chk("pass", o_pass, (exp_fc == 0) ? 1 : 0);
        chk("fail_count", o_fc, exp_fc);
        chk("err_a", o_ea, (first < 0) ? 0 : (first >> w));
        chk("err_b", o_eb, (first < 0) ? 0 : (first & ((1 << w) - 1)));
        chk("a_final", o_a, stopk >> w);
        chk("b_final", o_b, stopk & ((1 << w) - 1));
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", o_done, 1);
        chk("fc_hold", o_fc, exp_fc);
    endtask

    initial begin
        rst = 1'b1;
        st = 1'b0;
        sel = 1'b0;
        setup(0, 0);
        setup(1, 0);
        repeat (2) @(negedge clk);
        sel = 1'b0;
        #1;
        check_zero("reset_w1");
        sel = 1'b1;
        #1;
        check_zero("reset_w2");
        @(negedge clk);
        rst = 1'b0;

        setup(0, 0); run(0, -1, -1);
        setup(0, 1); run(0, -1, -1);
        setup(0, 2); run(0, -1, -1);
        setup(0, 3); run(0, -1, -1);
        setup(0, 0); run(0, -1, 5);
        run(0, -1, -1);

        setup(1, 0); run(1, 20, -1);
        for (int k = 0; k < 4; k++) begin
            setup(1, 4);
            run(1, -1, -1);
        end
        for (int k = 0; k < 4; k++) begin
            setup(0, 4);
            run(0, -1, -1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
